// File: rtl/matrix_block_reader.sv
// Streams one matrix slot out of the shared matrix BRAM in row-major order.
// A 2-entry tagged FIFO absorbs the 1-cycle BRAM latency under downstream backpressure.
module matrix_block_reader #(
    parameter int BLOCK_SIZE = 1152,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            matrix_id,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DIM_WIDTH-1:0]  out_row,
    output logic [DIM_WIDTH-1:0]  out_col,
    output logic                  out_last
);

    typedef enum logic [1:0] {IDLE, CHECK, READ, DRAIN} state_t;

    state_t                  state_q;
    logic                    busy_q, done_q, error_q;
    logic [ADDR_WIDTH-1:0]   base_q, addr_q;
    logic [DIM_WIDTH-1:0]    rows_q, cols_q, row_q, col_q;

    logic                    inflight_q;
    logic [DIM_WIDTH-1:0]    infl_row_q, infl_col_q;
    logic                    infl_last_q;

    logic [DATA_WIDTH-1:0]   fdata_q [2];
    logic [DIM_WIDTH-1:0]    frow_q  [2];
    logic [DIM_WIDTH-1:0]    fcol_q  [2];
    logic                    flast_q [2];
    logic                    rd_ptr_q, wr_ptr_q;
    logic [1:0]              count_q;

    logic                    pop, issue, issue_last, bad_dims;
    logic [2:0]              occupancy;
    logic [2*DIM_WIDTH-1:0]  area;
    logic [ADDR_WIDTH-1:0]   base_d;

    assign base_d     = ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
    assign area       = (2*DIM_WIDTH)'(rows_q) * (2*DIM_WIDTH)'(cols_q);
    assign bad_dims   = (rows_q == '0) || (cols_q == '0) || (area > (2*DIM_WIDTH)'(BLOCK_SIZE));

    assign pop        = (count_q != 2'd0) && out_ready;
    // Credit counts buffered plus in-flight words, freeing the slot popped this cycle.
    assign occupancy  = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue      = (state_q == READ) && (occupancy < 3'd2);
    assign issue_last = (row_q == rows_q - DIM_WIDTH'(1)) && (col_q == cols_q - DIM_WIDTH'(1));

    assign bram_en    = issue;
    assign bram_addr  = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign out_valid  = (count_q != 2'd0);
    assign out_data   = fdata_q[rd_ptr_q];
    assign out_row    = frow_q[rd_ptr_q];
    assign out_col    = fcol_q[rd_ptr_q];
    assign out_last   = flast_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            base_q      <= '0;
            addr_q      <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            inflight_q  <= 1'b0;
            infl_row_q  <= '0;
            infl_col_q  <= '0;
            infl_last_q <= 1'b0;
            fdata_q[0]  <= '0;
            fdata_q[1]  <= '0;
            frow_q[0]   <= '0;
            frow_q[1]   <= '0;
            fcol_q[0]   <= '0;
            fcol_q[1]   <= '0;
            flast_q[0]  <= 1'b0;
            flast_q[1]  <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                infl_row_q  <= row_q;
                infl_col_q  <= col_q;
                infl_last_q <= issue_last;
            end

            assert (!(inflight_q && !pop && count_q == 2'd2))
                else $error("matrix_block_reader: FIFO overflow");
            if (inflight_q) begin
                fdata_q[wr_ptr_q] <= bram_dout;
                frow_q[wr_ptr_q]  <= infl_row_q;
                fcol_q[wr_ptr_q]  <= infl_col_q;
                flast_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(inflight_q) - 2'(pop);

            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_d;
                        rows_q  <= rows;
                        cols_q  <= cols;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_dims) begin
                        error_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        busy_q  <= 1'b1;
                        row_q   <= '0;
                        col_q   <= '0;
                        addr_q  <= base_q;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (col_q == cols_q - DIM_WIDTH'(1)) begin
                            col_q <= '0;
                            row_q <= row_q + DIM_WIDTH'(1);
                        end else begin
                            col_q <= col_q + DIM_WIDTH'(1);
                        end
                        if (issue_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && flast_q[rd_ptr_q]) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
